// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_SW:   imm = IMM_S;
            OP_BR:   imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_ctrl.sv
// Combinational ALU-control sub-decoder: maps the FSM's coarse aluop plus
// instruction function fields to the ALU operation.
module multicycle_alu_ctrl
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7,
    output logic [2:0] alucontrol
);

    // Subtract only for R-type (op5=1) with funct7 set; addi ignores funct7.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 & funct7) alucontrol = ALU_SUB;
                        else              alucontrol = ALU_ADD;
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for a multicycle RV32I datapath with a shared memory
// port and shared ALU; emits per-cycle enables, mux selects and ALU control.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         immsrc,
    output logic [2:0]         alucontrol,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t     state_r;
    state_t     next_s;
    logic       mem_ok_s;
    logic [1:0] aluop_s;
    logic       pcupdate_s;
    logic       branch_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       done_s;
    logic       illegal_s;

    assign mem_ok_s = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // State register; reset returns to FETCH from any state, even mid-wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_FETCH;
        else       state_r <= next_s;
    end

    // Next-state and Moore output decode; every output defaults to 0.
    always_comb begin
        next_s     = S_FETCH;
        adrsrc     = 1'b0;
        resultsrc  = RES_ALUOUT;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        aluop_s    = ALUOP_ADD;
        pcupdate_s = 1'b0;
        branch_s   = 1'b0;
        irwrite_s  = 1'b0;
        memwrite_s = 1'b0;
        regwrite_s = 1'b0;
        done_s     = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            S_FETCH: begin
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURESULT;
                irwrite_s  = mem_ok_s;
                pcupdate_s = mem_ok_s;
                if (mem_ok_s) next_s = S_DECODE;
                else          next_s = S_FETCH;
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: next_s = S_MEMADR;
                    OP_R:         next_s = S_EXECR;
                    OP_I:         next_s = S_EXECI;
                    OP_JAL:       next_s = S_JAL;
                    OP_BR:        next_s = S_BEQ;
                    default: begin
                        next_s    = S_FETCH;
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                if (op == OP_LW) next_s = S_MEMREAD;
                else             next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ok_s) next_s = S_MEMWB;
                else          next_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_s = mem_ok_s;
                done_s     = mem_ok_s;
                if (mem_ok_s) next_s = S_FETCH;
                else          next_s = S_MEMWRITE;
            end
            S_MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite_s = 1'b1;
                done_s     = 1'b1;
                next_s     = S_FETCH;
            end
            S_EXECR: begin
                alusrca = SRCA_RS1;
                aluop_s = ALUOP_FUNCT;
                next_s  = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop_s = ALUOP_FUNCT;
                next_s  = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_s = 1'b1;
                done_s     = 1'b1;
                next_s     = S_FETCH;
            end
            S_JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                pcupdate_s = 1'b1;
                next_s     = S_ALUWB;
            end
            S_BEQ: begin
                alusrca  = SRCA_RS1;
                aluop_s  = ALUOP_SUB;
                branch_s = 1'b1;
                done_s   = 1'b1;
                next_s   = S_FETCH;
            end
            default: next_s = S_FETCH;
        endcase
    end

    multicycle_alu_ctrl u_alu_ctrl (
        .aluop      (aluop_s),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7     (funct7),
        .alucontrol (alucontrol)
    );

    // funct3[0] inverts the zero test, turning beq into bne.
    assign pcwrite    = ~reset & (pcupdate_s | (branch_s & (zero ^ funct3[0])));
    assign irwrite    = ~reset & irwrite_s;
    assign memwrite   = ~reset & memwrite_s;
    assign regwrite   = ~reset & regwrite_s;
    assign instr_done = ~reset & done_s;
    assign illegal_op = ~reset & illegal_s;
    assign immsrc     = imm_decode(op);
    assign dbg_state  = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push
// expected per-instruction summaries; a negedge monitor checks each retirement.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       mem_ready;
    logic       pcwrite, adrsrc, irwrite, memwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal_op;
    logic [3:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        int          cycles;
        logic [63:0] trace;
        int          nreg;
        int          nmem;
        int          npc;
        int          nill;
        logic [2:0]  alu;
        logic [1:0]  res;
        logic [1:0]  imm;
    } exp_t;

    exp_t q[$];

    multicycle_controller #(.USE_MEM_READY(1), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
        end
    endtask

    // Per-instruction observations, accumulated between retirements.
    int          m_cyc, m_reg, m_mem, m_pc, m_ill;
    logic [63:0] m_trace;
    logic [2:0]  m_alu;
    logic [1:0]  m_res, m_imm;

    task automatic mon_clear();
        m_cyc = 0; m_reg = 0; m_mem = 0; m_pc = 0; m_ill = 0;
        m_trace = 64'd0; m_alu = 3'b111; m_res = 2'b11; m_imm = 2'b00;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        if (reset) begin
            mon_clear();
        end else begin
            exp_t e;
            m_cyc++;
            m_trace = {m_trace[59:0], dbg_state};
            m_reg += int'(regwrite);
            m_mem += int'(memwrite);
            m_pc  += int'(pcwrite);
            m_ill += int'(illegal_op);
            if (dbg_state inside {4'd2, 4'd6, 4'd7, 4'd10}) m_alu = alucontrol;
            if (dbg_state == 4'd1) m_imm = immsrc;
            if (regwrite) m_res = resultsrc;
            if (instr_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_cycles"},   64'(m_cyc),   64'(e.cycles));
                    chk({e.name, "_trace"},    m_trace,      e.trace);
                    chk({e.name, "_regwrite"}, 64'(m_reg),   64'(e.nreg));
                    chk({e.name, "_memwrite"}, 64'(m_mem),   64'(e.nmem));
                    chk({e.name, "_pcwrite"},  64'(m_pc),    64'(e.npc));
                    chk({e.name, "_illegal"},  64'(m_ill),   64'(e.nill));
                    chk({e.name, "_aluctl"},   64'(m_alu),   64'(e.alu));
                    chk({e.name, "_result"},   64'(m_res),   64'(e.res));
                    chk({e.name, "_immsrc"},   64'(m_imm),   64'(e.imm));
                end
                mon_clear();
            end
        end
    end

    // Drives one instruction's fields for n cycles; mask bit i drops mem_ready in cycle i.
    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int n, input logic [15:0] mask);
        op = o; funct3 = f3; funct7 = f7; zero = z;
        for (int i = 0; i < n; i++) begin
            mem_ready = ~mask[i];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input logic [15:0] mask,
                         input int cyc, input logic [63:0] tr, input int nreg,
                         input int nmem, input int npc, input int nill,
                         input logic [2:0] alu, input logic [1:0] res, input logic [1:0] imm);
        exp_t e;
        e.name = nm; e.cycles = cyc; e.trace = tr; e.nreg = nreg; e.nmem = nmem;
        e.npc = npc; e.nill = nill; e.alu = alu; e.res = res; e.imm = imm;
        q.push_back(e);
        drive(o, f3, f7, z, cyc, mask);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state",    64'(dbg_state), 64'd0);
        chk("rst_irwrite",  64'(irwrite),   64'd0);
        chk("rst_pcwrite",  64'(pcwrite),   64'd0);
        chk("rst_alusrcb",  64'(alusrcb),   64'd2);
        chk("rst_result",   64'(resultsrc), 64'd2);
        reset = 1'b0;

        //     name       op            f3      f7    z     mask      cyc  trace            reg mem pc ill alu     res    imm
        issue("lw",      7'b0000011, 3'b010, 1'b0, 1'b0, 16'h0000, 5, 64'h01234,    1, 0, 1, 0, 3'b000, 2'b01, 2'b00);
        issue("sw_wait", 7'b0100011, 3'b010, 1'b0, 1'b0, 16'h0038, 7, 64'h0125555,  0, 1, 1, 0, 3'b000, 2'b11, 2'b01);
        issue("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 16'h0000, 3, 64'h01a,      0, 0, 2, 0, 3'b001, 2'b11, 2'b10);
        issue("beq_nt",  7'b1100011, 3'b000, 1'b0, 1'b0, 16'h0000, 3, 64'h01a,      0, 0, 1, 0, 3'b001, 2'b11, 2'b10);
        issue("bne_nt",  7'b1100011, 3'b001, 1'b0, 1'b1, 16'h0000, 3, 64'h01a,      0, 0, 1, 0, 3'b001, 2'b11, 2'b10);
        issue("bne_t",   7'b1100011, 3'b001, 1'b0, 1'b0, 16'h0000, 3, 64'h01a,      0, 0, 2, 0, 3'b001, 2'b11, 2'b10);
        issue("sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 16'h0000, 4, 64'h0168,     1, 0, 1, 0, 3'b001, 2'b00, 2'b00);
        issue("add",     7'b0110011, 3'b000, 1'b0, 1'b0, 16'h0000, 4, 64'h0168,     1, 0, 1, 0, 3'b000, 2'b00, 2'b00);
        issue("slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 16'h0000, 4, 64'h0168,     1, 0, 1, 0, 3'b101, 2'b00, 2'b00);
        issue("and",     7'b0110011, 3'b111, 1'b0, 1'b0, 16'h0000, 4, 64'h0168,     1, 0, 1, 0, 3'b010, 2'b00, 2'b00);
        issue("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 16'h0000, 4, 64'h0178,     1, 0, 1, 0, 3'b000, 2'b00, 2'b00);
        issue("ori",     7'b0010011, 3'b110, 1'b0, 1'b0, 16'h0000, 4, 64'h0178,     1, 0, 1, 0, 3'b011, 2'b00, 2'b00);
        issue("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 16'h0000, 4, 64'h0198,     1, 0, 2, 0, 3'b111, 2'b00, 2'b11);
        issue("illegal", 7'b1110011, 3'b000, 1'b0, 1'b0, 16'h0000, 2, 64'h01,       0, 0, 1, 1, 3'b111, 2'b11, 2'b00);
        issue("lw_wait", 7'b0000011, 3'b010, 1'b0, 1'b0, 16'h0023, 8, 64'h00012334, 1, 0, 1, 0, 3'b000, 2'b01, 2'b00);

        // Abort a load while it waits in MEMREAD, then restart cleanly.
        drive(7'b0000011, 3'b010, 1'b0, 1'b0, 4, 16'h0008);
        chk("abort_in_memread", 64'(dbg_state), 64'd3);
        #1 reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("mid_rst_state",    64'(dbg_state),  64'd0);
        chk("mid_rst_irwrite",  64'(irwrite),    64'd0);
        chk("mid_rst_pcwrite",  64'(pcwrite),    64'd0);
        chk("mid_rst_regwrite", 64'(regwrite),   64'd0);
        chk("mid_rst_memwrite", 64'(memwrite),   64'd0);
        chk("mid_rst_done",     64'(instr_done), 64'd0);
        chk("mid_rst_adrsrc",   64'(adrsrc),     64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("post_rst_irwrite", 64'(irwrite), 64'd1);
        chk("post_rst_pcwrite", 64'(pcwrite), 64'd1);
        issue("lw_after_rst", 7'b0000011, 3'b010, 1'b0, 1'b0, 16'h0000, 5, 64'h01234, 1, 0, 1, 0, 3'b000, 2'b01, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style sequencing FSM that controls a multicycle RV32I datapath with one shared memory port and one shared ALU.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Generates per-cycle enables and mux selects, plus ALU control through a combinational ALU-control sub-decoder.
- Sits between the instruction register (op/funct fields) and the datapath. Supports lw, sw, R-type, I-type ALU, jal, beq/bne.

Parameters:
USE_MEM_READY, 1, 1: FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0: mem_ready ignored and treated as 1
STATE_W, 4, width of the state register and of dbg_state

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH
op  input  7  instr[6:0] from the instruction register
funct3  input  3  instr[14:12]
funct7  input  1  instr[30]
zero  input  1  ALU zero flag, valid in the BEQ state
mem_ready  input  1  memory handshake; access completes in a cycle where it is 1
pcwrite  output  1  PC register enable
adrsrc  output  1  memory address select: 0=PC, 1=ALUOut
irwrite  output  1  instruction register and OldPC enable
memwrite  output  1  memory write strobe
regwrite  output  1  register file write enable
resultsrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
alusrca  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
alusrcb  output  2  ALU B select: 00=rs2, 01=ImmExt, 10=constant 4
immsrc  output  2  00=I, 01=S, 10=B, 11=J
alucontrol  output  3  000=add, 001=sub, 010=and, 011=or, 101=slt
instr_done  output  1  one-cycle pulse on the final cycle of each retired instruction
illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported
dbg_state  output  STATE_W  current state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, JAL=9, BEQ=10.
- Transitions:
  - FETCH to DECODE when mem_ready=1, else stay in FETCH.
  - DECODE by op:
    - 0000011 (lw) or 0100011 (sw) to MEMADR
    - 0110011 to EXECR
    - 0010011 to EXECI
    - 1101111 to JAL
    - 1100011 to BEQ
    - any other op to FETCH, with illegal_op=1
  - MEMADR: lw to MEMREAD, sw to MEMWRITE.
  - MEMREAD to MEMWB on mem_ready=1, else stay.
  - MEMWRITE to FETCH on mem_ready=1, else stay.
  - MEMWB to FETCH. EXECR, EXECI and JAL to ALUWB. ALUWB to FETCH. BEQ to FETCH.
  - Unused encodings go to FETCH.
- Outputs are 0 unless listed below:
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10; irwrite=mem_ready, pcupdate=mem_ready.
  - DECODE: alusrca=01, alusrcb=01, aluop=00 (branch/jump target precompute).
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: adrsrc=1, resultsrc=00.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=mem_ready.
  - MEMWB: resultsrc=01, regwrite=1.
  - EXECR: alusrca=10, alusrcb=00, aluop=10.
  - EXECI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
- pcwrite = pcupdate | (branch & (zero ^ funct3[0])). funct3=000 is beq; funct3=001 is bne.
- immsrc is decoded combinationally from op in every state: lw/I-type=00, sw=01, beq=10, jal=11, others=00.
- ALU-control mapping:
  - aluop=00 gives add; aluop=01 gives sub.
  - aluop=10 decodes funct3: 000 gives sub when op[5]&funct7=1, else add; 010 gives slt; 110 gives or; 111 gives and; others give add.
- instr_done is asserted in these cycles: MEMWB, ALUWB, BEQ, MEMWRITE with mem_ready=1, and DECODE with an illegal op.
- Latency with mem_ready always 1: lw 5 cycles, sw 4, R-type 4, I-type 4, jal 4, beq/bne 3. Each extra mem_ready=0 cycle in a wait state adds 1 cycle.
- Reset behaviour:
  - Asserting reset in any state, including mid-wait, sets state to FETCH immediately.
  - During reset all enables are forced to 0: pcwrite, irwrite, memwrite, regwrite, instr_done, illegal_op.
  - Selects take their FETCH values; dbg_state=0.
  - After release, the first fetch proceeds normally.
- Inputs are sampled only in the states that use them: op in DECODE/MEMADR, zero and funct3 in BEQ, mem_ready in wait states.

Decomposition:
- Shared package holds: state encodings, opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR), mux-select constants (RES_*, SRCA_*, SRCB_*, IMM_*), aluop codes and alucontrol codes.
- One sub-module, multicycle_alu_ctrl: combinational {aluop, funct3, op5, funct7} to alucontrol.
- The FSM and output decode stay in the top module.

Test Plan:
- lw, mem_ready=1: states 0,1,2,3,4,0. regwrite=1 only in state 4, with resultsrc=01. instr_done at cycle 5.
- sw with mem_ready=0 for 3 cycles in MEMWRITE: memwrite=0 during the wait, then a single memwrite=1 pulse; total 7 cycles; regwrite never asserted.
- beq with zero=1: pcwrite=1 in BEQ, alucontrol=001. bne (funct3=001) with zero=1: pcwrite=0.
- R-type sub (funct3=000, funct7=1): alucontrol=001 in EXECR. Same with funct7=0: 000. I-type addi with funct7=1: 000.
- op=1110011 in DECODE: illegal_op=1 and instr_done=1 for one cycle, next state FETCH, no regwrite/memwrite.
- Reset asserted mid-MEMREAD while mem_ready=0: state goes to 0 asynchronously and all enables go to 0. After release, FETCH with mem_ready=1 gives irwrite=1 and pcwrite=1.
